// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the reference-clocked system PLL: pulses the PLL reset, waits for
// lock with a retry timeout, qualifies lock stability, then releases the system reset.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 50,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic       lock_lost
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             retry_q, retry_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   locked_s;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
    assign locked_s = sync_q[SYNC_STAGES-1];

    // Lock has priority over the timeout; the shared counter restarts on every transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = RESET_PLL;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d     = WAIT_LOCK;
                    lock_lost_d = 1'b1;
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            sync_q      <= '0;
            retry_q     <= 8'd0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_rst     = (state_q == RESET_PLL);
    assign sys_rst     = (state_q != RUN);
    assign ready       = ~sys_rst;
    assign retry_count = retry_q;
    assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] retry_count;
    logic       lock_lost;

    int cyc = 0;
    int nTests = 0;
    int nFail = 0;

    typedef struct {
        int    cyc;
        logic  pll;
        logic  sys;
        logic  ll;
        int    rc;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t monE;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .retry_count(retry_count),
        .lock_lost  (lock_lost)
    );

    // Free-running reference clock and a cycle index counting rising edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one scoreboard entry against the outputs currently presented.
    task automatic checkOutput(input exp_t e);
        nTests++;
        if (e.cyc != cyc || pll_rst !== e.pll || sys_rst !== e.sys || ready !== ~e.sys ||
            lock_lost !== e.ll || retry_count !== 8'(e.rc)) begin
            nFail++;
            $display("[TB] FAIL %s @cyc %0d (checked %0d): got pll_rst=%b sys_rst=%b ready=%b lock_lost=%b retry_count=%0d, want %b %b %b %b %0d",
                     e.name, e.cyc, cyc, pll_rst, sys_rst, ready, lock_lost, retry_count,
                     e.pll, e.sys, ~e.sys, e.ll, e.rc);
        end
    endtask

    // Monitor: every falling edge, pop all entries due at (or overdue by) this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            monE = sb.pop_front();
            checkOutput(monE);
        end
    end

    task automatic expectAt(input int c, input logic pll, input logic sys, input logic ll,
                            input int rc, input string name);
        exp_t e;
        e.cyc  = c;
        e.pll  = pll;
        e.sys  = sys;
        e.ll   = ll;
        e.rc   = rc;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic l);
        rst    = r;
        locked = l;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tickTo(input int c);
        while (cyc < c) tick(1);
    endtask

    // Hold rst for n edges with locked low; base is the first cycle after release
    // in which the sequencer sits in RESET_PLL with a zero count.
    task automatic doReset(input int n, output int base);
        for (int k = 1; k <= n; k++) expectAt(cyc + k, 1'b1, 1'b1, 1'b0, 0, "resetValues");
        applyStimulus(1'b1, 1'b0);
        tick(n);
        base = cyc;
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic expectNoLock(input int b, input int periods, input int rc0, input string name);
        for (int p = 0; p < periods; p++)
            for (int k = 0; k < 24; k++)
                expectAt(b + 24*p + k, logic'(k < 4), 1'b1, 1'b0, rc0 + p, name);
    endtask

    // Directed scenarios, each pushing its hand-derived expectations before driving.
    initial begin
        int b;
        int b2;
        applyStimulus(1'b1, 1'b0);

        doReset(3, b);
        expectNoLock(b, 3, 0, "noLock");
        tickTo(b + 72);

        doReset(1, b);
        for (int k = 0; k < 4; k++)   expectAt(b + k, 1'b1, 1'b1, 1'b0, 0, "lockPllRst");
        for (int k = 4; k < 20; k++)  expectAt(b + k, 1'b0, 1'b1, 1'b0, 0, "lockWait");
        for (int k = 20; k < 26; k++) expectAt(b + k, 1'b0, 1'b0, 1'b0, 0, "lockRun");
        tickTo(b + 9);
        locked = 1'b1;
        tickTo(b + 26);

        doReset(1, b);
        for (int k = 0; k < 4; k++)   expectAt(b + k, 1'b1, 1'b1, 1'b0, 0, "glitchPllRst");
        for (int k = 4; k < 29; k++)  expectAt(b + k, 1'b0, 1'b1, 1'b0, 0, "glitchRestart");
        for (int k = 29; k < 34; k++) expectAt(b + k, 1'b0, 1'b0, 1'b0, 0, "glitchRun");
        expectAt(b + 34, 1'b0, 1'b1, 1'b1, 0, "lockLostPulse");
        for (int k = 35; k < 48; k++) expectAt(b + k, 1'b0, 1'b1, 1'b0, 0, "relockWait");
        for (int k = 48; k < 51; k++) expectAt(b + k, 1'b0, 1'b0, 1'b0, 0, "relockRun");
        tickTo(b + 9);
        locked = 1'b1;
        tickTo(b + 17);
        locked = 1'b0;
        tickTo(b + 18);
        locked = 1'b1;
        tickTo(b + 31);
        locked = 1'b0;
        tickTo(b + 37);
        locked = 1'b1;
        tickTo(b + 51);

        doReset(1, b);
        expectNoLock(b, 3, 0, "midNoLock");
        for (int k = 72; k < 76; k++) expectAt(b + k, 1'b1, 1'b1, 1'b0, 3, "midPllRst");
        for (int k = 76; k < 88; k++) expectAt(b + k, 1'b0, 1'b1, 1'b0, 3, "midWait");
        for (int k = 88; k < 91; k++) expectAt(b + k, 1'b0, 1'b0, 1'b0, 3, "midRun");
        tickTo(b + 77);
        locked = 1'b1;
        tickTo(b + 90);
        doReset(1, b2);
        expectNoLock(b2, 1, 0, "afterMidReset");
        expectAt(b2 + 24, 1'b1, 1'b1, 1'b0, 1, "afterMidRetry");
        tickTo(b2 + 25);

        doReset(1, b);
        for (int p = 0; p < 300; p++) begin
            if (p > 0) expectAt(b + 24*p - 1, 1'b0, 1'b1, 1'b0, (p - 1 > 255) ? 255 : p - 1, "satWaitEnd");
            expectAt(b + 24*p, 1'b1, 1'b1, 1'b0, (p > 255) ? 255 : p, "satPllRst");
            expectAt(b + 24*p + 4, 1'b0, 1'b1, 1'b0, (p > 255) ? 255 : p, "satWait");
        end
        tickTo(b + 24*300 + 5);

        tick(2);
        while (sb.size() > 0) begin
            monE = sb.pop_front();
            nTests++;
            nFail++;
            $display("[TB] FAIL %s @cyc %0d: never checked, still pending at cyc %0d", monE.name, monE.cyc, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    // Watchdog so a stuck run still reports and stops.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cyc %0d, want completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
